// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: one bus fetch per PC, holds the PC until the
// instruction returns, buffers it across stalls, drops responses made stale by
// a flush. Optional `IFETCH_PERF_EN adds fetch and wait-cycle counters.
module inst_fetch_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        adel_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic        inst_stall_o,
    output logic        inst_valid_o,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_adel_o
`ifdef IFETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt_o,
    output logic [31:0] perf_wait_cnt_o
`endif
);

    typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [31:0] req_pc_q, req_pc_d;
    logic [31:0] buf_inst_q, buf_inst_d;
    logic [31:0] buf_pc_q, buf_pc_d;
    logic        valid_q, valid_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_q, pc_d;
    logic        adel_q, adel_d;
    logic        done;

    assign done = (state_q == S_REQ  && adel_i && !stall_i) ||
                  (state_q == S_WAIT && inst_data_ok_i && !stall_i) ||
                  (state_q == S_HOLD && !stall_i);

    assign inst_stall_o = !done;
    assign inst_addr_o  = pc_i;

    // A flush never cancels the bus transaction; if one is still in flight
    // past this edge, DISCARD swallows its data_ok.
    always_comb begin
        state_d    = state_q;
        inst_req_o = 1'b0;
        unique case (state_q)
            S_REQ: begin
                inst_req_o = !adel_i;
                if (!adel_i && inst_addr_ok_i)
                    state_d = flush_i ? S_DISCARD : S_WAIT;
            end
            S_WAIT: begin
                if (flush_i)
                    state_d = inst_data_ok_i ? S_REQ : S_DISCARD;
                else if (inst_data_ok_i)
                    state_d = stall_i ? S_HOLD : S_REQ;
            end
            S_HOLD: begin
                if (flush_i || !stall_i)
                    state_d = S_REQ;
            end
            S_DISCARD: begin
                if (inst_data_ok_i)
                    state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    always_comb begin
        req_pc_d   = req_pc_q;
        buf_inst_d = buf_inst_q;
        buf_pc_d   = buf_pc_q;
        valid_d    = valid_q;
        inst_d     = inst_q;
        pc_d       = pc_q;
        adel_d     = adel_q;

        if (state_q == S_REQ && !adel_i && inst_addr_ok_i)
            req_pc_d = pc_i;

        if (state_q == S_WAIT && inst_data_ok_i && stall_i) begin
            buf_inst_d = inst_rdata_i;
            buf_pc_d   = req_pc_q;
        end

        if (flush_i) begin
            valid_d = 1'b0;
        end else if (done) begin
            valid_d = 1'b1;
            unique case (state_q)
                S_REQ: begin
                    inst_d = 32'h0;
                    pc_d   = pc_i;
                    adel_d = 1'b1;
                end
                S_HOLD: begin
                    inst_d = buf_inst_q;
                    pc_d   = buf_pc_q;
                    adel_d = 1'b0;
                end
                default: begin
                    inst_d = inst_rdata_i;
                    pc_d   = req_pc_q;
                    adel_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_REQ;
            req_pc_q   <= 32'h0;
            buf_inst_q <= 32'h0;
            buf_pc_q   <= 32'h0;
            valid_q    <= 1'b0;
            inst_q     <= 32'h0;
            pc_q       <= 32'h0;
            adel_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_pc_q   <= req_pc_d;
            buf_inst_q <= buf_inst_d;
            buf_pc_q   <= buf_pc_d;
            valid_q    <= valid_d;
            inst_q     <= inst_d;
            pc_q       <= pc_d;
            adel_q     <= adel_d;
        end
    end

    assign inst_valid_o = valid_q;
    assign inst_o       = inst_q;
    assign inst_pc_o    = pc_q;
    assign inst_adel_o  = adel_q;

`ifdef IFETCH_PERF_EN
    logic [31:0] fetch_cnt_q, fetch_cnt_d;
    logic [31:0] wait_cnt_q, wait_cnt_d;

    // Wait cycles are those where fetch, not the pipeline, is the bottleneck.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q + {31'h0, done};
        wait_cnt_d  = wait_cnt_q + {31'h0, inst_stall_o && !stall_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= 32'h0;
            wait_cnt_q  <= 32'h0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
        end
    end

    assign perf_fetch_cnt_o = fetch_cnt_q;
    assign perf_wait_cnt_o  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Bench for inst_fetch_ctrl: directed scenarios plus random bus/pipeline
// traffic, all checked against a transaction-level queue model.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        adel_i, stall_i, flush_i;
    logic        inst_req_o;
    logic [31:0] inst_addr_o;
    logic        inst_addr_ok_i, inst_data_ok_i;
    logic [31:0] inst_rdata_i;
    logic        inst_stall_o, inst_valid_o;
    logic [31:0] inst_o, inst_pc_o;
    logic        inst_adel_o;
`ifdef IFETCH_PERF_EN
    logic [31:0] perf_fetch_cnt_o, perf_wait_cnt_o;
`endif

    inst_fetch_ctrl dut (
        .clk(clk), .rst(rst), .pc_i(pc_i), .adel_i(adel_i), .stall_i(stall_i),
        .flush_i(flush_i), .inst_req_o(inst_req_o), .inst_addr_o(inst_addr_o),
        .inst_addr_ok_i(inst_addr_ok_i), .inst_data_ok_i(inst_data_ok_i),
        .inst_rdata_i(inst_rdata_i), .inst_stall_o(inst_stall_o),
        .inst_valid_o(inst_valid_o), .inst_o(inst_o), .inst_pc_o(inst_pc_o),
        .inst_adel_o(inst_adel_o)
`ifdef IFETCH_PERF_EN
        , .perf_fetch_cnt_o(perf_fetch_cnt_o), .perf_wait_cnt_o(perf_wait_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    // Model: bus transactions in flight (live=0 once a flush made them stale),
    // fetched instructions waiting for the pipeline, and the visible output.
    typedef struct packed { logic [31:0] pc; logic live; } txn_t;
    typedef struct packed { logic [31:0] inst; logic [31:0] pc; logic adel; } fetch_t;

    txn_t   outq[$];
    fetch_t heldq[$];
    logic   m_valid;
    fetch_t m_out;
    int     vectors = 0;
    int     errors  = 0;

    task automatic cycle(input logic [31:0] pc, input logic stall, input logic flush,
                         input logic aok, input logic dok, input logic [31:0] rdata);
        logic   req_e, has_d;
        fetch_t d;
        txn_t   t;
        @(negedge clk);
        pc_i           = pc;
        adel_i         = (pc[1:0] != 2'b00);
        stall_i        = stall;
        flush_i        = flush;
        inst_addr_ok_i = aok;
        inst_data_ok_i = dok && (outq.size() != 0);
        inst_rdata_i   = rdata;
        #1;
        req_e = (outq.size() == 0) && (heldq.size() == 0) && !adel_i;
        has_d = 1'b0;
        d     = '0;
        if (heldq.size() != 0) begin
            if (!stall) begin has_d = 1'b1; d = heldq[0]; end
        end else if (outq.size() != 0) begin
            if (inst_data_ok_i && outq[0].live && !stall) begin
                has_d = 1'b1; d = '{rdata, outq[0].pc, 1'b0};
            end
        end else if (adel_i && !stall) begin
            has_d = 1'b1; d = '{32'h0, pc, 1'b1};
        end

        vectors++;
        if (inst_req_o !== req_e) begin
            errors++; $display("FAIL req: got %b want %b (pc %h)", inst_req_o, req_e, pc);
        end
        vectors++;
        if (inst_addr_o !== pc) begin
            errors++; $display("FAIL addr: got %h want %h", inst_addr_o, pc);
        end
        vectors++;
        if (inst_stall_o !== !has_d) begin
            errors++; $display("FAIL stall_o: got %b want %b", inst_stall_o, !has_d);
        end
        vectors++;
        if (inst_valid_o !== m_valid) begin
            errors++; $display("FAIL valid: got %b want %b", inst_valid_o, m_valid);
        end
        if (m_valid) begin
            vectors++;
            if ({inst_o, inst_pc_o, inst_adel_o} !== m_out) begin
                errors++;
                $display("FAIL out: got inst %h pc %h adel %b want inst %h pc %h adel %b",
                         inst_o, inst_pc_o, inst_adel_o, m_out.inst, m_out.pc, m_out.adel);
            end
        end

        @(posedge clk);
        if (has_d) begin m_out = d; m_valid = 1'b1; end
        if (heldq.size() != 0 && !stall) void'(heldq.pop_front());
        if (outq.size() != 0 && inst_data_ok_i) begin
            t = outq.pop_front();
            if (t.live && !flush && stall) heldq.push_back('{rdata, t.pc, 1'b0});
        end
        if (req_e && aok) outq.push_back('{pc, !flush});
        if (flush) begin
            foreach (outq[i]) outq[i].live = 1'b0;
            heldq.delete();
            m_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; pc_i = 32'h0; adel_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        inst_addr_ok_i = 1'b0; inst_data_ok_i = 1'b0; inst_rdata_i = 32'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if ({inst_valid_o, inst_o, inst_pc_o, inst_adel_o} !== 66'h0) begin
            errors++;
            $display("FAIL reset_out: got valid %b inst %h pc %h adel %b want all 0",
                     inst_valid_o, inst_o, inst_pc_o, inst_adel_o);
        end
        rst = 1'b0;
        outq.delete(); heldq.delete(); m_valid = 1'b0; m_out = '0;
        #1;
        vectors++;
        if (inst_req_o !== 1'b1) begin
            errors++; $display("FAIL reset_req: got %b want 1", inst_req_o);
        end
    endtask

    task automatic test_basic();
        cycle(32'hbfc00000, 0, 0, 1, 0, 32'h0);
        cycle(32'hbfc00000, 0, 0, 0, 1, 32'h3c1d0001);
        #1;
        vectors++;
        if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h3c1d0001, 32'hbfc00000}) begin
            errors++;
            $display("FAIL basic: got valid %b inst %h pc %h want 1 3c1d0001 bfc00000",
                     inst_valid_o, inst_o, inst_pc_o);
        end
    endtask

    task automatic test_stall_hold();
        cycle(32'hbfc00004, 0, 0, 1, 0, 32'h0);
        cycle(32'hbfc00004, 1, 0, 1, 1, 32'h12345678);
        cycle(32'hbfc00004, 1, 0, 1, 0, 32'h0);
        cycle(32'hbfc00004, 1, 0, 1, 0, 32'h0);
        #1;
        vectors++;
        if (inst_o !== 32'h3c1d0001) begin
            errors++; $display("FAIL hold_keep: got %h want 3c1d0001", inst_o);
        end
        cycle(32'hbfc00004, 0, 0, 0, 0, 32'h0);
        #1;
        vectors++;
        if ({inst_valid_o, inst_o, inst_pc_o} !== {1'b1, 32'h12345678, 32'hbfc00004}) begin
            errors++;
            $display("FAIL hold_release: got valid %b inst %h pc %h want 1 12345678 bfc00004",
                     inst_valid_o, inst_o, inst_pc_o);
        end
    endtask

    task automatic test_flush_wait();
        cycle(32'hbfc00008, 0, 0, 1, 0, 32'h0);
        cycle(32'hbfc00380, 0, 1, 0, 0, 32'h0);
        cycle(32'hbfc00380, 0, 0, 1, 0, 32'h0);
        cycle(32'hbfc00380, 0, 0, 1, 1, 32'hdeadbeef);
        #1;
        vectors++;
        if (inst_valid_o !== 1'b0 || inst_o === 32'hdeadbeef || inst_req_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_wait: got valid %b inst %h req %b want 0 !deadbeef 1",
                     inst_valid_o, inst_o, inst_req_o);
        end
        cycle(32'hbfc00380, 0, 0, 1, 0, 32'h0);
        cycle(32'hbfc00380, 0, 0, 0, 1, 32'h24080001);
    endtask

    task automatic test_adel();
        cycle(32'hbfc00002, 0, 0, 1, 0, 32'h0);
        #1;
        vectors++;
        if ({inst_valid_o, inst_adel_o, inst_o, inst_pc_o, inst_req_o} !==
            {1'b1, 1'b1, 32'h0, 32'hbfc00002, 1'b0}) begin
            errors++;
            $display("FAIL adel: got valid %b adel %b inst %h pc %h req %b want 1 1 0 bfc00002 0",
                     inst_valid_o, inst_adel_o, inst_o, inst_pc_o, inst_req_o);
        end
    endtask

    task automatic test_flush_data_ok();
        cycle(32'hbfc00010, 0, 0, 1, 0, 32'h0);
        cycle(32'hbfc00010, 0, 1, 0, 1, 32'hcafef00d);
        #1;
        vectors++;
        if (inst_req_o !== 1'b1 || inst_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_dok: got req %b valid %b want 1 0", inst_req_o, inst_valid_o);
        end
    endtask

`ifdef IFETCH_PERF_EN
    task automatic test_perf();
        logic [31:0] f0, w0;
        #1;
        f0 = perf_fetch_cnt_o; w0 = perf_wait_cnt_o;
        for (int i = 0; i < 4; i++) begin
            cycle(32'hbfc00100 + 32'(4 * i), 0, 0, 1, 0, 32'h0);
            cycle(32'hbfc00100 + 32'(4 * i), 0, 0, 0, 1, $urandom);
        end
        #1;
        vectors++;
        if (perf_fetch_cnt_o - f0 !== 32'd4 || perf_wait_cnt_o - w0 !== 32'd4) begin
            errors++;
            $display("FAIL perf: got fetch +%0d wait +%0d want +4 +4",
                     perf_fetch_cnt_o - f0, perf_wait_cnt_o - w0);
        end
    endtask
`endif

    task automatic test_random();
        logic [31:0] p;
        for (int i = 0; i < 600; i++) begin
            p = $urandom;
            if ($urandom_range(0, 7) != 0) p[1:0] = 2'b00;
            else if (p[1:0] == 2'b00) p[0] = 1'b1;
            cycle(p, $urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 4) < 3, $urandom_range(0, 4) < 3, $urandom);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_hold();
        test_flush_wait();
        test_adel();
        test_flush_data_ok();
`ifdef IFETCH_PERF_EN
        test_perf();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
